sd_block_rx: RTL and testbench

- Receive-data stage of the SPI-mode SD path, sitting directly downstream of sd_read.
- After sd_read issues CMD17 and gets R1, this block samples SD_MISO, byte-aligned with the SD clock.
- It hunts for the start token, deserialises one data block MSB-first and streams the bytes out with a write address.
- It checks the trailing CRC16 and reports a single completion status to the controller.

---
 rtl/sd_pkg.sv | 22 ++
 rtl/sd_crc16.sv | 26 ++
 rtl/sd_block_rx.sv | 155 +++++++++++++++
 tb/tb_sd_block_rx.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// Shared constants, status codes and state enum for the SD SPI data path.
// Imported by sd_crc16 and sd_block_rx.
package sd_pkg;

  localparam logic [7:0]  START_TOKEN = 8'hFE;
  localparam logic [7:0]  IDLE_BYTE   = 8'hFF;
  localparam logic [15:0] CRC_POLY    = 16'h1021;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_CRC     = 2'd1;
  localparam logic [1:0] ST_TOKEN   = 2'd2;
  localparam logic [1:0] ST_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_CRC,
    S_FINISH
  } state_t;

endpackage

// File: rtl/sd_crc16.sv
// Bit-serial CRC16-CCITT (init 0, MSB first, no reflection, no final xor).
// Ports: clk, rst (sync high), clear, en, din (data bit), crc (16-bit result).
module sd_crc16
  import sd_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);

  logic fb;

  assign fb = din ^ crc[15];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      crc <= '0;
    end else if (en) begin
      crc <= {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    end
  end

endmodule

// File: rtl/sd_block_rx.sv
// SD SPI-mode block receiver: token hunt, MSB-first deserialiser, CRC16 check.
// Ports: clk, rst, sample_en, miso, start -> busy, rd_data/rd_valid/rd_addr,
//        done pulse, status (held), err_token (held).
module sd_block_rx
  import sd_pkg::*;
#(
  parameter int BLOCK_BYTES   = 512,
  parameter int TOKEN_TIMEOUT = 4096,
  parameter int ADDR_W        = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_en,
  input  logic              miso,
  input  logic              start,
  output logic              busy,
  output logic [7:0]        rd_data,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              done,
  output logic [1:0]        status,
  output logic [3:0]        err_token
);

  localparam int TW = $clog2(TOKEN_TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(BLOCK_BYTES - 1);
  localparam logic [TW-1:0] TMAX = TW'(TOKEN_TIMEOUT);

  state_t            state;
  logic [6:0]        sh;
  logic [2:0]        bcnt;
  logic [ADDR_W-1:0] idx;
  logic [TW-1:0]     tcnt;
  logic [14:0]       crc_sh;
  logic [3:0]        ccnt;
  logic [15:0]       crc;

  logic              take;
  logic              accept;
  logic              last_bit;
  logic [7:0]        byte_nxt;
  logic [15:0]       crc_nxt;

  // Samples only count while a transfer is actually receiving.
  assign take = sample_en &&
                (state == S_WAIT ||
                 state == S_DATA ||
                 state == S_CRC);

  assign accept   = (state == S_IDLE) && start;
  assign last_bit = (bcnt == 3'd7);
  assign byte_nxt = {sh, miso};
  assign crc_nxt  = {crc_sh, miso};

  sd_crc16 u_crc (
    .clk   (clk),
    .rst   (rst),
    .clear (accept),
    .en    (take && state == S_DATA),
    .din   (miso),
    .crc   (crc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      sh        <= '0;
      bcnt      <= '0;
      idx       <= '0;
      tcnt      <= '0;
      crc_sh    <= '0;
      ccnt      <= '0;
      busy      <= 1'b0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      rd_addr   <= '0;
      done      <= 1'b0;
      status    <= ST_OK;
      err_token <= '0;
    end else begin
      rd_valid <= 1'b0;
      done     <= 1'b0;
      if (take) begin
        sh   <= byte_nxt[6:0];
        bcnt <= bcnt + 3'd1;
      end
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_WAIT;
            busy      <= 1'b1;
            status    <= ST_OK;
            err_token <= '0;
            bcnt      <= '0;
            idx       <= '0;
            tcnt      <= '0;
            ccnt      <= '0;
          end
        end
        S_WAIT: begin
          if (take && last_bit) begin
            if (byte_nxt == START_TOKEN) begin
              state <= S_DATA;
            end else if (byte_nxt[7:4] == 4'h0) begin
              status    <= ST_TOKEN;
              err_token <= byte_nxt[3:0];
              done      <= 1'b1;
              state     <= S_FINISH;
            end else begin
              // Saturating: the limit ends the wait before any wrap.
              if (tcnt != TMAX) begin
                tcnt <= tcnt + TW'(1);
              end
              if (tcnt + TW'(1) == TMAX) begin
                status <= ST_TIMEOUT;
                done   <= 1'b1;
                state  <= S_FINISH;
              end
            end
          end
        end
        S_DATA: begin
          if (take && last_bit) begin
            rd_valid <= 1'b1;
            rd_data  <= byte_nxt;
            rd_addr  <= idx;
            if (idx == LAST) begin
              idx   <= '0;
              state <= S_CRC;
            end else begin
              idx <= idx + ADDR_W'(1);
            end
          end
        end
        S_CRC: begin
          if (take) begin
            crc_sh <= crc_nxt[14:0];
            ccnt   <= ccnt + 4'd1;
            if (ccnt == 4'd15) begin
              status <= (crc_nxt == crc) ? ST_OK : ST_CRC;
              done   <= 1'b1;
              state  <= S_FINISH;
            end
          end
        end
        S_FINISH: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_block_rx.sv
// Directed/randomised bench for sd_block_rx with a byte-level reference model.
// Drives stimulus on negedge, records DUT pulses 1 time unit after posedge.
module tb_sd_block_rx;

  localparam int BB = 512;
  localparam int TT = 4096;

  logic       clk = 1'b0;
  logic       rst;
  logic       sample_en;
  logic       miso;
  logic       start;
  logic       busy;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [8:0] rd_addr;
  logic       done;
  logic [1:0] status;
  logic [3:0] err_token;

  always #5 clk = ~clk;

  sd_block_rx #(
    .BLOCK_BYTES   (BB),
    .TOKEN_TIMEOUT (TT),
    .ADDR_W        (9)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sample_en (sample_en),
    .miso      (miso),
    .start     (start),
    .busy      (busy),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_addr   (rd_addr),
    .done      (done),
    .status    (status),
    .err_token (err_token)
  );

  int tests = 0;
  int fails = 0;

  logic [7:0] blk [BB];
  logic [7:0] got_d [$];
  int         got_a [$];
  int         done_cnt = 0;
  int         gap_mode = 0;
  int         start_at = -1;
  int         bit_n = 0;

  always @(posedge clk) begin
    #1;
    if (rd_valid) begin
      got_d.push_back(rd_data);
      got_a.push_back(int'(rd_addr));
    end
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference CRC16-CCITT, byte-at-a-time formulation.
  function automatic logic [15:0] crc_ref();
    logic [15:0] c;
    c = 16'h0000;
    for (int i = 0; i < BB; i++) begin
      c = c ^ {blk[i], 8'h00};
      for (int k = 0; k < 8; k++) begin
        if (c[15]) c = (c << 1) ^ 16'h1021;
        else       c = c << 1;
      end
    end
    return c;
  endfunction

  task automatic send_bit(input logic b);
    int g;
    if (gap_mode == 0)      g = 0;
    else if (gap_mode == 1) g = 1;
    else                    g = $urandom_range(1, 7);
    repeat (g) @(negedge clk);
    sample_en = 1'b1;
    miso      = b;
    start     = (bit_n == start_at);
    bit_n++;
    @(negedge clk);
    sample_en = 1'b0;
    start     = 1'b0;
    miso      = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic do_start(input logic with_sample);
    got_d.delete();
    got_a.delete();
    done_cnt  = 0;
    bit_n     = 0;
    start     = 1'b1;
    sample_en = with_sample;
    miso      = 1'b0;
    @(negedge clk);
    start     = 1'b0;
    sample_en = 1'b0;
    miso      = 1'b1;
    check("busy_after_start", busy, 1);
  endtask

  task automatic run_block(input string tag, input int npre,
                           input logic [15:0] crc_val,
                           input logic [1:0] exp_st,
                           input logic with_sample);
    int bad;
    do_start(with_sample);
    repeat (npre) send_byte(8'hFF);
    send_byte(8'hFE);
    for (int i = 0; i < BB; i++) send_byte(blk[i]);
    for (int i = 15; i >= 1; i--) send_bit(crc_val[i]);
    check({tag, "_early_done"}, done_cnt, 0);
    send_bit(crc_val[0]);
    check({tag, "_done"}, done, 1);
    check({tag, "_busy_at_done"}, busy, 1);
    check({tag, "_status"}, status, exp_st);
    @(negedge clk);
    check({tag, "_done_off"}, done, 0);
    check({tag, "_busy_off"}, busy, 0);
    check({tag, "_rd_count"}, got_d.size(), BB);
    bad = 0;
    for (int i = 0; i < got_d.size() && i < BB; i++) begin
      if (got_d[i] !== blk[i] || got_a[i] != i) bad++;
    end
    check({tag, "_rd_bytes"}, bad, 0);
    check({tag, "_done_count"}, done_cnt, 1);
  endtask

  initial begin
    logic [15:0] c;
    rst       = 1'b1;
    sample_en = 1'b0;
    miso      = 1'b1;
    start     = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_valid", rd_valid, 0);
    check("rst_done", done, 0);
    check("rst_status", status, 0);
    check("rst_err", err_token, 0);
    check("rst_data", {rd_data, 7'h0, rd_addr}, 0);

    // All-zero block; start coincides with a sample that must be dropped.
    gap_mode = 0;
    for (int i = 0; i < BB; i++) blk[i] = 8'h00;
    run_block("zero", 3, 16'h0000, 2'd0, 1'b1);

    // All-0xFF block, good and bad CRC.
    for (int i = 0; i < BB; i++) blk[i] = 8'hFF;
    run_block("ff_ok", 0, 16'h7FA1, 2'd0, 1'b0);
    run_block("ff_bad", 0, 16'h7FA0, 2'd1, 1'b0);
    check("ff_bad_held", status, 1);

    // Data error token after idle bytes.
    do_start(1'b0);
    repeat (5) send_byte(8'hFF);
    send_byte(8'h08);
    check("tok_done", done, 1);
    check("tok_status", status, 2);
    check("tok_err", err_token, 4'h8);
    check("tok_no_data", got_d.size(), 0);
    @(negedge clk);
    check("tok_busy_off", busy, 0);
    repeat (4) @(negedge clk);
    check("tok_status_held", status, 2);
    check("tok_err_held", err_token, 4'h8);

    // Token timeout.
    do_start(1'b0);
    check("to_err_cleared", {status, err_token}, 0);
    repeat (TT - 1) send_byte(8'hFF);
    check("to_early_done", done_cnt, 0);
    send_byte(8'hFF);
    check("to_done", done, 1);
    check("to_status", status, 3);
    @(negedge clk);
    check("to_busy_off", busy, 0);
    check("to_done_count", done_cnt, 1);

    // Reset in the middle of a block.
    gap_mode = 1;
    for (int i = 0; i < BB; i++) blk[i] = 8'($urandom);
    do_start(1'b0);
    send_byte(8'hFE);
    for (int i = 0; i <= 100; i++) send_byte(blk[i]);
    check("mid_count", got_d.size(), 101);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_busy", busy, 0);
    check("mid_valid", rd_valid, 0);
    check("mid_outs", {rd_data, 7'h0, rd_addr, 2'b0, status}, 0);
    check("mid_no_done", done_cnt, 0);
    gap_mode = 0;
    for (int i = 0; i < BB; i++) blk[i] = 8'($urandom);
    run_block("after_rst", 2, crc_ref(), 2'd0, 1'b0);

    // Random sample gaps plus a stray start while busy.
    gap_mode = 2;
    for (int i = 0; i < BB; i++) blk[i] = 8'($urandom);
    start_at = int'($urandom_range(40, 3000));
    run_block("gaps", 1, crc_ref(), 2'd0, 1'b0);
    start_at = -1;

    // Random data with one flipped CRC bit.
    gap_mode = 0;
    for (int i = 0; i < BB; i++) blk[i] = 8'($urandom);
    c = crc_ref() ^ (16'h1 << $urandom_range(0, 15));
    run_block("rnd_bad", 4, c, 2'd1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
